// File: rtl/axi_tdd_ng_pkg.sv
// Shared types and constants for the TDD sync monitor.
// Provides the monitor state encoding and the default counter width.
package axi_tdd_ng_pkg;

  localparam int SYNC_COUNT_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    ACQUIRE    = 2'd2,
    LOCKED     = 2'd3
  } sync_state_t;

endpackage

// File: rtl/axi_tdd_ng_sync_win.sv
// Combinational sync window compare on the interval count.
// In: cnt, period, tol. Out: in_window, early, timeout.
import axi_tdd_ng_pkg::*;

module axi_tdd_ng_sync_win #(
  parameter int W = SYNC_COUNT_WIDTH_DEF
) (
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] period,
  input  logic [W-1:0] tol,
  output logic         in_window,
  output logic         early,
  output logic         timeout
);

  logic [W:0] c1;
  logic [W:0] p1;
  logic [W:0] t1;
  logic [W:0] lo;
  logic [W:0] hi;

  // One extra bit so P+T and the timeout point never wrap.
  always_comb begin
    c1 = {1'b0, cnt};
    p1 = {1'b0, period};
    t1 = {1'b0, tol};
    lo = (t1 >= p1) ? (W+1)'(1) : (p1 - t1);
    hi = p1 + t1;
    in_window = (c1 >= lo) && (c1 <= hi);
    early     = (c1 < lo);
    timeout   = (c1 == hi + (W+1)'(1));
  end

endmodule

// File: rtl/axi_tdd_ng_sync_mon.sv
// Qualifies an incoming frame-sync train, acquires/holds lock, flywheels.
// Ports: clk/resetn, sync_in, enable/rearm/period/tol in; sync/status out.
import axi_tdd_ng_pkg::*;

module axi_tdd_ng_sync_mon #(
  parameter int SYNC_COUNT_WIDTH = SYNC_COUNT_WIDTH_DEF,
  parameter int LOCK_COUNT       = 4,
  parameter int LOSS_COUNT       = 2,
  parameter int ERR_CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        sync_in,
  input  logic                        tdd_enable,
  input  logic                        tdd_sync_rearm,
  input  logic [SYNC_COUNT_WIDTH-1:0] tdd_sync_period,
  input  logic [SYNC_COUNT_WIDTH-1:0] tdd_sync_tolerance,
  output logic                        sync_out,
  output logic                        sync_locked,
  output logic [SYNC_COUNT_WIDTH-1:0] sync_period_meas,
  output logic                        sync_err_early,
  output logic                        sync_err_late,
  output logic [ERR_CNT_WIDTH-1:0]    sync_err_count
);

  localparam int W  = SYNC_COUNT_WIDTH;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);

  sync_state_t   state;
  sync_state_t   state_n;
  logic          sync_in_d;
  logic          ev;
  logic [W-1:0]  cnt;
  logic [W-1:0]  cnt_n;
  logic [W-1:0]  cnt_inc;
  logic [GW-1:0] good;
  logic [GW-1:0] good_n;
  logic [BW-1:0] bad;
  logic [BW-1:0] bad_n;
  logic [W-1:0]  meas_n;
  logic          out_n;
  logic          early_n;
  logic          late_n;
  logic          clr_err;
  logic          in_window;
  logic          early;
  logic          timeout;
  logic          bad_hit;

  assign ev      = sync_in & ~sync_in_d;
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  axi_tdd_ng_sync_win #(
    .W (W)
  ) u_win (
    .cnt       (cnt),
    .period    (tdd_sync_period),
    .tol       (tdd_sync_tolerance),
    .in_window (in_window),
    .early     (early),
    .timeout   (timeout)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    good_n  = good;
    bad_n   = bad;
    meas_n  = sync_period_meas;
    out_n   = 1'b0;
    early_n = 1'b0;
    late_n  = 1'b0;
    clr_err = 1'b0;
    bad_hit = 1'b0;
    if (!tdd_enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      good_n  = '0;
      bad_n   = '0;
      clr_err = 1'b1;
    end else if (tdd_sync_rearm) begin
      // A rearm in IDLE just clears; the P>=2 gate still applies.
      state_n = (state == IDLE) ? IDLE : WAIT_FIRST;
      cnt_n   = '0;
      good_n  = '0;
      bad_n   = '0;
      clr_err = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n  = '0;
          good_n = '0;
          bad_n  = '0;
          if (tdd_sync_period >= W'(2))
            state_n = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (ev) begin
            cnt_n   = W'(1);
            good_n  = '0;
            state_n = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (timeout) begin
            late_n  = 1'b1;
            good_n  = '0;
            state_n = WAIT_FIRST;
          end else if (ev && in_window) begin
            cnt_n  = W'(1);
            meas_n = cnt;
            good_n = good + 1'b1;
            if (good == GW'(LOCK_COUNT - 1)) begin
              state_n = LOCKED;
              out_n   = 1'b1;
              bad_n   = '0;
            end
          end else if (ev && early) begin
            early_n = 1'b1;
            good_n  = '0;
            cnt_n   = W'(1);
          end
        end
        LOCKED: begin
          if (timeout) begin
            // Realign to where the missed nominal edge would have been.
            out_n   = 1'b1;
            late_n  = 1'b1;
            cnt_n   = tdd_sync_tolerance + W'(2);
            bad_hit = 1'b1;
          end else if (ev && in_window) begin
            out_n  = 1'b1;
            meas_n = cnt;
            cnt_n  = W'(1);
            bad_n  = '0;
          end else if (ev && early) begin
            early_n = 1'b1;
            bad_hit = 1'b1;
          end
          if (bad_hit) begin
            if (bad == BW'(LOSS_COUNT - 1)) begin
              state_n = WAIT_FIRST;
              good_n  = '0;
              bad_n   = '0;
            end else begin
              bad_n = bad + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      sync_in_d        <= 1'b0;
      cnt              <= '0;
      good             <= '0;
      bad              <= '0;
      sync_out         <= 1'b0;
      sync_locked      <= 1'b0;
      sync_period_meas <= '0;
      sync_err_early   <= 1'b0;
      sync_err_late    <= 1'b0;
      sync_err_count   <= '0;
    end else begin
      state            <= state_n;
      sync_in_d        <= sync_in;
      cnt              <= cnt_n;
      good             <= good_n;
      bad              <= bad_n;
      sync_out         <= out_n;
      sync_locked      <= (state_n == LOCKED);
      sync_period_meas <= meas_n;
      sync_err_early   <= early_n;
      sync_err_late    <= late_n;
      if (clr_err)
        sync_err_count <= '0;
      else if ((early_n || late_n) && !(&sync_err_count))
        sync_err_count <= sync_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_tdd_ng_sync_mon.sv
// Scoreboard bench for the TDD sync monitor.
// Expected pulses are queued at stimulus time and matched at the outputs.
module tb_axi_tdd_ng_sync_mon;

  localparam int W  = 16;
  localparam int EW = 2;

  localparam logic [2:0] K_OUT   = 3'b100;
  localparam logic [2:0] K_EARLY = 3'b010;
  localparam logic [2:0] K_FLY   = 3'b101;
  localparam logic [2:0] K_NONE  = 3'b000;

  typedef struct {
    logic [2:0] p;
    int         meas;
    int         cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sync_in = 1'b0;
  logic          tdd_enable = 1'b0;
  logic          tdd_sync_rearm = 1'b0;
  logic [W-1:0]  tdd_sync_period = 16'd10;
  logic [W-1:0]  tdd_sync_tolerance = 16'd1;
  logic          sync_out;
  logic          sync_locked;
  logic [W-1:0]  sync_period_meas;
  logic          sync_err_early;
  logic          sync_err_late;
  logic [EW-1:0] sync_err_count;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_drive = 0;
  int   exp_err = 0;
  exp_t sb[$];

  axi_tdd_ng_sync_mon #(
    .SYNC_COUNT_WIDTH (W),
    .LOCK_COUNT       (4),
    .LOSS_COUNT       (2),
    .ERR_CNT_WIDTH    (EW)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .sync_in            (sync_in),
    .tdd_enable         (tdd_enable),
    .tdd_sync_rearm     (tdd_sync_rearm),
    .tdd_sync_period    (tdd_sync_period),
    .tdd_sync_tolerance (tdd_sync_tolerance),
    .sync_out           (sync_out),
    .sync_locked        (sync_locked),
    .sync_period_meas   (sync_period_meas),
    .sync_err_early     (sync_err_early),
    .sync_err_late      (sync_err_late),
    .sync_err_count     (sync_err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] p, input int meas, input int c);
    exp_t e;
    e.p    = p;
    e.meas = meas;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // One rising sync edge, then idle so the next edge lands gap cycles later.
  task automatic edge_gap(input logic [2:0] k, input int meas, input int gap);
    last_drive = cyc;
    if (k != K_NONE)
      push(k, meas, cyc + 1);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    repeat (gap - 1) tick();
  endtask

  always @(negedge clk) begin
    logic [2:0] obs;
    exp_t       e;
    obs = {sync_out, sync_err_early, sync_err_late};
    if (resetn && obs != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 64'(obs), 64'(0));
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 64'(obs), 64'(e.p));
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        if (e.meas >= 0)
          check("meas", 64'(sync_period_meas), 64'(e.meas));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_out", 64'(sync_out), 64'(0));
    check("rst_locked", 64'(sync_locked), 64'(0));
    check("rst_meas", 64'(sync_period_meas), 64'(0));
    check("rst_errcnt", 64'(sync_err_count), 64'(0));
    check("rst_late", 64'(sync_err_late), 64'(0));
    tick();
    resetn = 1'b1;
    tick();
    tdd_enable = 1'b1;
    tick();
    tick();

    // Acquire: four silent edges, lock on the fifth.
    repeat (4) edge_gap(K_NONE, 0, 10);
    check("unlocked_e4", 64'(sync_locked), 64'(0));
    edge_gap(K_OUT, 10, 10);
    check("locked_e5", 64'(sync_locked), 64'(1));
    edge_gap(K_OUT, 10, 11);

    // Late-but-in-window edge, then nominal.
    edge_gap(K_OUT, 11, 10);
    edge_gap(K_OUT, 10, 8);

    // Early edge ignored for timing, then edge at original cnt=10.
    edge_gap(K_EARLY, -1, 2);
    exp_err = 1;
    check("errcnt_early", 64'(sync_err_count), 64'(exp_err));
    check("locked_early", 64'(sync_locked), 64'(1));
    edge_gap(K_OUT, 10, 1);

    // Sync stops: two flywheel timeouts drop lock.
    push(K_FLY, -1, last_drive + 13);
    push(K_FLY, -1, last_drive + 23);
    repeat (17) tick();
    check("locked_fly1", 64'(sync_locked), 64'(1));
    repeat (7) tick();
    check("locked_fly2", 64'(sync_locked), 64'(0));
    exp_err = exp_err + 2;
    if (exp_err > 3) exp_err = 3;
    check("errcnt_late", 64'(sync_err_count), 64'(exp_err));

    // Relock, then rearm coincident with an edge.
    repeat (4) edge_gap(K_NONE, 0, 10);
    edge_gap(K_OUT, 10, 10);
    check("relocked", 64'(sync_locked), 64'(1));
    sync_in = 1'b1;
    tdd_sync_rearm = 1'b1;
    tick();
    sync_in = 1'b0;
    tdd_sync_rearm = 1'b0;
    check("rearm_locked", 64'(sync_locked), 64'(0));
    check("rearm_errcnt", 64'(sync_err_count), 64'(0));
    repeat (9) tick();
    repeat (4) edge_gap(K_NONE, 0, 10);
    check("rearm_unlocked", 64'(sync_locked), 64'(0));
    edge_gap(K_OUT, 10, 4);
    check("rearm_relock", 64'(sync_locked), 64'(1));

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_locked", 64'(sync_locked), 64'(0));
    check("arst_meas", 64'(sync_period_meas), 64'(0));
    check("arst_out", 64'(sync_out), 64'(0));
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();

    // Early edges in ACQUIRE saturate the 2-bit error count.
    exp_err = 0;
    edge_gap(K_NONE, 0, 5);
    for (int i = 0; i < 5; i++) begin
      edge_gap(K_EARLY, -1, 5);
      if (exp_err < 3) exp_err++;
    end
    check("errcnt_sat", 64'(sync_err_count), 64'(exp_err));
    check("sat_meas", 64'(sync_period_meas), 64'(0));

    tdd_enable = 1'b0;
    tick();
    tick();
    check("dis_errcnt", 64'(sync_err_count), 64'(0));
    check("dis_locked", 64'(sync_locked), 64'(0));

    // Period below 2 keeps the monitor idle.
    tdd_sync_period = 16'd1;
    tdd_enable = 1'b1;
    tick();
    repeat (6) edge_gap(K_NONE, 0, 10);
    check("p1_locked", 64'(sync_locked), 64'(0));
    check("p1_errcnt", 64'(sync_err_count), 64'(0));

    repeat (3) tick();
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
